// File: rtl/auth_resp_arbiter.sv
// auth_resp_arbiter: shares one authentication responder among N_REQ requesters
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   req_valid, req_msg  - per-requester request level and flattened message
//   req_grant/done/timeout/busy - per-requester status back to the front ends
//   resp_req_in, auth_msg_resp_in, slot, Ack_in - drive the responder
//   resp_req_out, current_timeout - responder ready flag and its timeout in cycles
//   active              - high whenever the arbiter is not idle
// Build option: define AUTH_ARB_FIXED_PRIO_EN for fixed lowest-index priority
//   instead of round-robin arbitration.
`ifndef MSG_LEN
`define MSG_LEN 16
`endif

module auth_resp_arbiter #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*`MSG_LEN-1:0] req_msg,
    output logic [N_REQ-1:0]          req_grant,
    output logic [N_REQ-1:0]          req_done,
    output logic [N_REQ-1:0]          req_timeout,
    output logic [N_REQ-1:0]          req_busy,
    output logic                      resp_req_in,
    output logic [`MSG_LEN-1:0]       auth_msg_resp_in,
    output logic [1:0]                slot,
    output logic                      Ack_in,
    input  logic                      resp_req_out,
    input  logic [31:0]               current_timeout,
    output logic                      active
);
    typedef enum logic [2:0] {IDLE, GRANT, WAIT_RESP, ACK, TIMEOUT, RELEASE} state_t;
    state_t state_q, state_d;
    logic [1:0] ptr_q, ptr_d, slot_q, slot_d, win;
    logic [N_REQ-1:0] grant_q, grant_d, done_q, done_d, tmo_q, tmo_d, busy_q, busy_d;
    logic [`MSG_LEN-1:0] msg_q, msg_d, win_msg;
    logic rri_q, rri_d, ack_q, ack_d, active_q, active_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

    // Winner: lowest pending index at or above the pointer, else lowest overall.
    always_comb begin
        win = 2'd0;
        win_msg = '0;
        for (int i = N_REQ - 1; i >= 0; i--) if (req_valid[i]) win = 2'(i);
        for (int i = N_REQ - 1; i >= 0; i--) if (req_valid[i] && i >= int'(ptr_q)) win = 2'(i);
        for (int i = 0; i < N_REQ; i++) if (win == 2'(i)) win_msg = req_msg[i*`MSG_LEN +: `MSG_LEN];
    end

    // The timeout test uses the incremented count so TIMEOUT follows exactly
    // current_timeout WAIT_RESP cycles.
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        slot_d = slot_q;
        msg_d = msg_q;
        grant_d = grant_q;
        rri_d = rri_q;
        cnt_d = cnt_q;
        done_d = '0;
        tmo_d = '0;
        ack_d = 1'b0;
        case (state_q)
            IDLE: if (|req_valid) begin
                state_d = GRANT;
                slot_d = win;
                msg_d = win_msg;
                grant_d = N_REQ'(1) << win;
            end
            GRANT: if (!req_valid[slot_q]) begin
                state_d = RELEASE;
                grant_d = '0;
            end else begin
                state_d = WAIT_RESP;
                rri_d = 1'b1;
                cnt_d = '0;
            end
            WAIT_RESP: begin
                cnt_d = cnt_inc;
                if (!req_valid[slot_q]) begin
                    state_d = RELEASE;
                    rri_d = 1'b0;
                    grant_d = '0;
                end else if (resp_req_out) begin
                    state_d = ACK;
                    ack_d = 1'b1;
                    done_d[slot_q] = 1'b1;
                end else if (current_timeout != 32'd0 && cnt_inc >= CNT_W'(current_timeout)) begin
                    state_d = TIMEOUT;
                    tmo_d[slot_q] = 1'b1;
                    rri_d = 1'b0;
                end
            end
            ACK, TIMEOUT: begin
                state_d = RELEASE;
                rri_d = 1'b0;
                grant_d = '0;
            end
            RELEASE: begin
                state_d = IDLE;
`ifndef AUTH_ARB_FIXED_PRIO_EN
                ptr_d = (int'(slot_q) == N_REQ - 1) ? 2'd0 : slot_q + 2'd1;
`endif
            end
            default: state_d = IDLE;
        endcase
        active_d = state_d != IDLE;
        busy_d = (state_d != IDLE) ? req_valid & ~(N_REQ'(1) << slot_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q <= '0;
            slot_q <= '0;
            msg_q <= '0;
            grant_q <= '0;
            done_q <= '0;
            tmo_q <= '0;
            busy_q <= '0;
            rri_q <= 1'b0;
            ack_q <= 1'b0;
            active_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            slot_q <= slot_d;
            msg_q <= msg_d;
            grant_q <= grant_d;
            done_q <= done_d;
            tmo_q <= tmo_d;
            busy_q <= busy_d;
            rri_q <= rri_d;
            ack_q <= ack_d;
            active_q <= active_d;
            cnt_q <= cnt_d;
        end
    end

    assign req_grant = grant_q;
    assign req_done = done_q;
    assign req_timeout = tmo_q;
    assign req_busy = busy_q;
    assign resp_req_in = rri_q;
    assign auth_msg_resp_in = msg_q;
    assign slot = slot_q;
    assign Ack_in = ack_q;
    assign active = active_q;
endmodule
